// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Define UART_ARB_PKT_LOCK_EN to hold the grant on one requester until its packet's last byte.
`timescale 1ns/1ps
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic [7:0]                 snd_data,
   output logic                       snd_ready,
   input  logic                       snd_busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       arb_busy,
   output logic                       drop_err
);
   localparam int IDW = $clog2(NUM_REQ);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] SEND      = 2'd1;
   localparam logic [1:0] WAIT_BUSY = 2'd2;
   localparam logic [1:0] WAIT_DONE = 2'd3;

   localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);
   localparam logic [7:0]     TO_LAST  = 8'(BUSY_TIMEOUT - 1);

   logic [1:0]     state_q, state_d;
   logic [IDW-1:0] last_q, last_d;
   logic [IDW-1:0] gid_q, gid_d;
   logic [7:0]     data_q, data_d;
   logic [7:0]     cnt_q, cnt_d;
   logic           drop_q, drop_d;

   logic           rr_found, found;
   logic [IDW-1:0] rr_win, win;
   logic [7:0]     win_data;

   // Round robin: indices above last_q first, then wrap to the low indices.
   always_comb begin
      rr_found = 1'b0;
      rr_win   = last_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!rr_found && req_valid[i] && (IDW'(i) > last_q)) begin
            rr_found = 1'b1;
            rr_win   = IDW'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!rr_found && req_valid[i] && (IDW'(i) <= last_q)) begin
            rr_found = 1'b1;
            rr_win   = IDW'(i);
         end
      end
   end

`ifdef UART_ARB_PKT_LOCK_EN
   logic lock_q, lock_d;

   // A locked packet waits only on its own requester, however long that takes.
   assign found = lock_q ? req_valid[last_q] : rr_found;
   assign win   = lock_q ? last_q : rr_win;
`else
   logic unused_req_last;

   assign unused_req_last = ^req_last;
   assign found           = rr_found;
   assign win             = rr_win;
`endif

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (IDW'(i) == win) win_data = req_data[8*i +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gid_d   = gid_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      drop_d  = 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
      lock_d  = lock_q;
`endif
      case (state_q)
         IDLE: begin
            if (!snd_busy && found) begin
               data_d  = win_data;
               gid_d   = win;
               last_d  = win;
               state_d = SEND;
            end
         end
         SEND: begin
            state_d = WAIT_BUSY;
            cnt_d   = '0;
`ifdef UART_ARB_PKT_LOCK_EN
            lock_d  = !req_last[gid_q];
`endif
         end
         WAIT_BUSY: begin
            if (snd_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == TO_LAST) begin
               // Transmitter never started: the byte is dropped, not re-acked.
               drop_d  = 1'b1;
               state_d = IDLE;
`ifdef UART_ARB_PKT_LOCK_EN
               lock_d  = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         WAIT_DONE: begin
            if (!snd_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= LAST_RST;
         gid_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         drop_q  <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
         lock_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gid_q   <= gid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
`ifdef UART_ARB_PKT_LOCK_EN
         lock_q  <= lock_d;
`endif
      end
   end

   always_comb begin
      req_ack = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ack[i] = (state_q == SEND) && (gid_q == IDW'(i));
      end
   end

   assign snd_data  = data_q;
   assign snd_ready = (state_q == SEND);
   assign grant_id  = gid_q;
   assign arb_busy  = (state_q != IDLE);
   assign drop_err  = drop_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with three requesters and a simple transmitter model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   localparam int NREQ = 3;
   localparam int TO   = 16;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid, req_last, req_ack;
   logic [8*NREQ-1:0]   req_data;
   logic [7:0]          snd_data;
   logic                snd_ready, snd_busy, arb_busy, drop_err;
   logic [1:0]          grant_id;

   uart_tx_arbiter #(.NUM_REQ(NREQ), .BUSY_TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ack   (req_ack),
      .snd_data  (snd_data),
      .snd_ready (snd_ready),
      .snd_busy  (snd_busy),
      .grant_id  (grant_id),
      .arb_busy  (arb_busy),
      .drop_err  (drop_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0, bad = 0;
   int send_cnt = 0, send_cyc = 0, drop_cnt = 0, drop_cyc = 0;
   int load_cyc = 0, fall_cyc = 0, busy_len = 5;
   bit model_en = 1'b1;

   logic [8:0] rq0[$], rq1[$], rq2[$];
   logic [9:0] sbq[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outs(input string pfx);
      check_eq({pfx, "_snd_data"},  32'(snd_data),  0);
      check_eq({pfx, "_snd_ready"}, 32'(snd_ready), 0);
      check_eq({pfx, "_req_ack"},   32'(req_ack),   0);
      check_eq({pfx, "_grant_id"},  32'(grant_id),  0);
      check_eq({pfx, "_arb_busy"},  32'(arb_busy),  0);
      check_eq({pfx, "_drop_err"},  32'(drop_err),  0);
   endtask

   task automatic expect_send(input logic [1:0] id, input logic [7:0] d);
      sbq.push_back({id, d});
   endtask

   task automatic do_reset();
      sbq.delete();
      send_cnt = 0;
      drop_cnt = 0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #2;
   endtask

   task automatic wait_sends(input int n, input int max);
      int k = 0;
      while (send_cnt < n && k < max) begin
         @(negedge clk);
         k++;
      end
      check_eq("send_count", send_cnt, n);
   endtask

   task automatic settle();
      int k = 0;
      while ((snd_busy || arb_busy) && k < 400) begin
         @(negedge clk);
         k++;
      end
      check_eq("settle_idle", 32'(arb_busy), 0);
   endtask

   // Requesters: present queue heads, pop on the cycle after an observed ack.
   initial begin
      logic [NREQ-1:0] ack_s, prev;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         ack_s = req_ack;
         @(posedge clk);
         #1;
         if (ack_s[0] && rq0.size() > 0) void'(rq0.pop_front());
         if (ack_s[1] && rq1.size() > 0) void'(rq1.pop_front());
         if (ack_s[2] && rq2.size() > 0) void'(rq2.pop_front());
         prev = req_valid;
         req_valid[0] = (rq0.size() > 0);
         req_valid[1] = (rq1.size() > 0);
         req_valid[2] = (rq2.size() > 0);
         if (rq0.size() > 0) begin req_data[7:0]   = rq0[0][7:0]; req_last[0] = rq0[0][8]; end
         if (rq1.size() > 0) begin req_data[15:8]  = rq1[0][7:0]; req_last[1] = rq1[0][8]; end
         if (rq2.size() > 0) begin req_data[23:16] = rq2[0][7:0]; req_last[2] = rq2[0][8]; end
         if ((req_valid & ~prev) != '0) load_cyc = cyc;
      end
   end

   // Transmitter: busy rises one cycle after a send pulse and lasts busy_len cycles.
   initial begin
      snd_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (snd_ready && model_en) begin
            @(posedge clk);
            #1 snd_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 snd_busy = 1'b0;
            fall_cyc = cyc;
         end
      end
   end

   initial begin
      logic [9:0] e;
      forever begin
         @(negedge clk);
         if (snd_ready) begin
            send_cnt++;
            send_cyc = cyc;
            if (sbq.size() == 0) begin
               check_eq("unexpected_send", 32'(snd_data), 32'hffff_ffff);
            end else begin
               e = sbq.pop_front();
               check_eq("snd_data", 32'(snd_data), 32'(e[7:0]));
               check_eq("grant_id", 32'(grant_id), 32'(e[9:8]));
               check_eq("req_ack",  32'(req_ack),  32'(1) << e[9:8]);
            end
            check_eq("drop_with_ready", 32'(drop_err), 0);
         end else if (req_ack != '0) begin
            check_eq("ack_without_ready", 32'(req_ack), 0);
         end
         if (drop_err) begin
            drop_cnt++;
            drop_cyc = cyc;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #1 check_reset_outs("por");
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Single request with a 100-cycle frame
      do_reset();
      busy_len = 100;
      rq0.push_back({1'b0, 8'h41});
      expect_send(2'd0, 8'h41);
      wait_sends(1, 20);
      check_eq("t1_latency", send_cyc - load_cyc, 1);
      k = 0;
      while (!snd_busy && k < 10) begin @(negedge clk); k++; end
      while (snd_busy && k < 200) begin @(negedge clk); k++; end
      check_eq("t1_busy_at_fall", 32'(arb_busy), 1);
      @(negedge clk);
      check_eq("t1_idle_after_fall", 32'(arb_busy), 0);

      // Contention across all three requesters
      do_reset();
      busy_len = 5;
      rq0.push_back({1'b0, 8'h10});
      rq0.push_back({1'b0, 8'h10});
      rq1.push_back({1'b0, 8'h20});
      rq2.push_back({1'b0, 8'h30});
      expect_send(2'd0, 8'h10);
      expect_send(2'd1, 8'h20);
      expect_send(2'd2, 8'h30);
      expect_send(2'd0, 8'h10);
      wait_sends(4, 200);
      settle();
      check_eq("t2_sb_empty", sbq.size(), 0);

      // Busy never rises
      do_reset();
      model_en = 1'b0;
      rq1.push_back({1'b0, 8'h55});
      expect_send(2'd1, 8'h55);
      wait_sends(1, 20);
      repeat (TO + 5) @(negedge clk);
      check_eq("t3_drop_count", drop_cnt, 1);
      check_eq("t3_drop_time", drop_cyc - send_cyc, TO + 1);
      check_eq("t3_idle", 32'(arb_busy), 0);
      model_en = 1'b1;
      rq2.push_back({1'b0, 8'h66});
      expect_send(2'd2, 8'h66);
      wait_sends(2, 20);
      settle();

      // Transmitter busy before any grant
      do_reset();
      snd_busy = 1'b1;
      rq0.push_back({1'b0, 8'h77});
      expect_send(2'd0, 8'h77);
      repeat (50) @(negedge clk);
      check_eq("t4_no_send_while_busy", send_cnt, 0);
      @(posedge clk);
      #1 snd_busy = 1'b0;
      fall_cyc = cyc;
      wait_sends(1, 10);
      check_eq("t4_send_after_fall", send_cyc - fall_cyc, 1);
      settle();

      // Packet of three bytes from req0 against a continuously valid req1
      do_reset();
      busy_len = 3;
      rq0.push_back({1'b0, 8'hA0});
      rq0.push_back({1'b0, 8'hA1});
      rq0.push_back({1'b1, 8'hA2});
      rq1.push_back({1'b0, 8'hB0});
      rq1.push_back({1'b1, 8'hB1});
`ifdef UART_ARB_PKT_LOCK_EN
      expect_send(2'd0, 8'hA0);
      expect_send(2'd0, 8'hA1);
      expect_send(2'd0, 8'hA2);
      expect_send(2'd1, 8'hB0);
      expect_send(2'd1, 8'hB1);
`else
      expect_send(2'd0, 8'hA0);
      expect_send(2'd1, 8'hB0);
      expect_send(2'd0, 8'hA1);
      expect_send(2'd1, 8'hB1);
      expect_send(2'd0, 8'hA2);
`endif
      wait_sends(5, 300);
      settle();
      check_eq("t5_sb_empty", sbq.size(), 0);

      // Reset while the transmitter frame is in flight
      do_reset();
      busy_len = 100;
      rq0.push_back({1'b0, 8'h11});
      rq0.push_back({1'b0, 8'h13});
      rq1.push_back({1'b0, 8'h22});
      expect_send(2'd0, 8'h11);
      expect_send(2'd0, 8'h13);
      expect_send(2'd1, 8'h22);
      wait_sends(1, 20);
      repeat (10) @(negedge clk);
      check_eq("t6_in_wait_done", 32'(arb_busy), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outs("t6_rst");
      @(posedge clk);
      #2 rst_n = 1'b1;
      k = 0;
      while (snd_busy && k < 200) begin @(negedge clk); k++; end
      wait_sends(2, 10);
      check_eq("t6_send_after_fall", send_cyc - fall_cyc, 1);
      wait_sends(3, 300);
      settle();
      check_eq("t6_sb_empty", sbq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
